// File: rtl/mult_bist_ctrl.sv
// rtl/mult_bist_ctrl.sv - built-in self-test controller for a signed WIDTH x WIDTH multiplier
//
// Drives a multiplier with three directed operand pairs, then NUM_VECTORS
// pseudo-random pairs from a 32-bit Galois LFSR. Checks every returned product
// against a signed reference delayed by LATENCY+1 edges. Reports done, pass and
// a saturating error count.
//
// Optional feature macro: MULT_BIST_FAIL_CAPTURE_EN
//   defined   : fail_a/fail_b/fail_product hold the first mismatch of a run
//   undefined : fail_* are tied to zero
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   single-cycle run request (ignored while busy)
//   mult_a       out  registered signed operand A to the multiplier
//   mult_b       out  registered signed operand B to the multiplier
//   mult_product in   signed 2*WIDTH product from the multiplier
//   busy         out  run in progress
//   done         out  sticky run-complete flag
//   pass         out  done and no mismatches
//   err_count    out  saturating mismatch count
//   fail_a       out  operand A of the first mismatch
//   fail_b       out  operand B of the first mismatch
//   fail_product out  product observed at the first mismatch
`timescale 1ns/1ps

module mult_bist_ctrl #(
  parameter int          WIDTH       = 8,
  parameter int          NUM_VECTORS = 50,
  parameter int          LATENCY     = 0,
  parameter logic [31:0] SEED        = 32'hACE1_2468
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     mult_a,
  output logic [WIDTH-1:0]     mult_b,
  input  logic [2*WIDTH-1:0]   mult_product,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic [2*WIDTH-1:0]   fail_product
);

  localparam int          PW        = 2 * WIDTH;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIR   = 3'd1,
    RND   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state;
  logic [1:0]      dir_idx;
  logic [15:0]     rnd_cnt;
  logic [15:0]     drain_cnt;
  logic [31:0]     lfsr;

  // Check pipeline: stage 0 is loaded on the issue edge, stage LATENCY is the
  // tail that lines up with the product currently on mult_product.
  logic [LATENCY:0] pv;
  logic [PW-1:0]    pexp [LATENCY+1];

  logic             issue;
  logic             start_edge;
  logic             mism;
  logic [WIDTH-1:0] na;
  logic [WIDTH-1:0] nb;

  function automatic logic [WIDTH-1:0] max_pos();
    return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // Directed constants are truncated to WIDTH so narrow builds stay legal.
  function automatic logic [WIDTH-1:0] dir_a(input logic [1:0] idx);
    logic [31:0] m5;
    m5 = 32'hFFFF_FFFB;
    case (idx)
      2'd0:    return '0;
      2'd1:    return max_pos();
      default: return m5[WIDTH-1:0];
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] dir_b(input logic [1:0] idx);
    logic [31:0] c15;
    logic [31:0] c10;
    c15 = 32'd15;
    c10 = 32'd10;
    case (idx)
      2'd0:    return c15[WIDTH-1:0];
      2'd1:    return max_pos();
      default: return c10[WIDTH-1:0];
    endcase
  endfunction

  function automatic logic [PW-1:0] smul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [PW-1:0] ea;
    logic signed [PW-1:0] eb;
    ea = $signed(a);
    eb = $signed(b);
    return ea * eb;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ LFSR_MASK;
    return n;
  endfunction

  assign start_edge = start && ((state == IDLE) || (state == DONE));
  assign mism       = pv[LATENCY] && (mult_product != pexp[LATENCY]);
  assign pass       = done && (err_count == 16'd0);

  // Next operand pair; IDLE/DONE with start issues directed vector 0 directly.
  always_comb begin
    issue = 1'b0;
    na    = mult_a;
    nb    = mult_b;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          issue = 1'b1;
          na    = dir_a(2'd0);
          nb    = dir_b(2'd0);
        end
      end
      DIR: begin
        issue = 1'b1;
        na    = dir_a(dir_idx);
        nb    = dir_b(dir_idx);
      end
      RND: begin
        issue = 1'b1;
        na    = lfsr[WIDTH-1:0];
        nb    = lfsr[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dir_idx   <= 2'd0;
      rnd_cnt   <= 16'd0;
      drain_cnt <= 16'd0;
      lfsr      <= SEED;
      mult_a    <= '0;
      mult_b    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= 16'd0;
      pv        <= '0;
      for (int i = 0; i <= LATENCY; i++) pexp[i] <= '0;
    end else begin
      for (int i = LATENCY; i > 0; i--) begin
        pv[i]   <= pv[i-1];
        pexp[i] <= pexp[i-1];
      end
      pv[0]   <= issue;
      pexp[0] <= smul(na, nb);

      if (issue) begin
        mult_a <= na;
        mult_b <= nb;
      end

      if (mism && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;

      case (state)
        IDLE, DONE: begin
          // Placed after the check so the run-start clear takes priority.
          if (start) begin
            state     <= DIR;
            dir_idx   <= 2'd1;
            busy      <= 1'b1;
            done      <= 1'b0;
            err_count <= 16'd0;
            lfsr      <= SEED;
          end
        end
        DIR: begin
          if (dir_idx == 2'd2) begin
            state   <= RND;
            rnd_cnt <= 16'd0;
          end else begin
            dir_idx <= dir_idx + 2'd1;
          end
        end
        RND: begin
          lfsr <= lfsr_step(lfsr);
          if (rnd_cnt == 16'(NUM_VECTORS - 1)) begin
            state     <= DRAIN;
            drain_cnt <= 16'd0;
          end else begin
            rnd_cnt <= rnd_cnt + 16'd1;
          end
        end
        DRAIN: begin
          // The last vector reaches the tail LATENCY edges after entering DRAIN.
          if (drain_cnt == 16'(LATENCY)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULT_BIST_FAIL_CAPTURE_EN
  logic [WIDTH-1:0] pa [LATENCY+1];
  logic [WIDTH-1:0] pb [LATENCY+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_a       <= '0;
      fail_b       <= '0;
      fail_product <= '0;
      for (int i = 0; i <= LATENCY; i++) begin
        pa[i] <= '0;
        pb[i] <= '0;
      end
    end else begin
      for (int i = LATENCY; i > 0; i--) begin
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
      pa[0] <= na;
      pb[0] <= nb;

      if (start_edge) begin
        fail_a       <= '0;
        fail_b       <= '0;
        fail_product <= '0;
      end else if (mism && (err_count == 16'd0)) begin
        fail_a       <= pa[LATENCY];
        fail_b       <= pb[LATENCY];
        fail_product <= mult_product;
      end
    end
  end
`else
  assign fail_a       = '0;
  assign fail_b       = '0;
  assign fail_product = '0;
`endif

endmodule

// File: tb/tb_mult_bist_ctrl.sv
// tb/tb_mult_bist_ctrl.sv - scoreboard bench for mult_bist_ctrl
`timescale 1ns/1ps

module tb_mult_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] smul8(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] x;
    logic signed [15:0] y;
    x = $signed(a);
    y = $signed(b);
    return x * y;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- DUT A: combinational multiplier with optional +1 fault
  logic        rst_a = 1'b0;
  logic        start_a = 1'b0;
  logic        fault_a = 1'b0;
  logic [7:0]  ma, mb, fa_a, fb_a;
  logic [15:0] prod_a, err_a, fp_a;
  logic        busy_a, done_a, pass_a;

  assign prod_a = smul8(ma, mb) + {15'd0, fault_a};

  mult_bist_ctrl #(.WIDTH(8), .NUM_VECTORS(4), .LATENCY(0)) dut_a (
    .clk(clk), .rst_n(rst_a), .start(start_a), .mult_a(ma), .mult_b(mb),
    .mult_product(prod_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_a(fa_a), .fail_b(fb_a), .fail_product(fp_a)
  );

  // ---------------- DUTs B/C/D: latency and saturation cases
  logic        rst_x = 1'b0;
  logic        start_x = 1'b0;
  logic [7:0]  xa [3];
  logic [7:0]  xb [3];
  logic [15:0] xp [3];
  logic        busy_x [3];
  logic        done_x [3];
  logic        pass_x [3];
  logic [15:0] err_x [3];
  logic [7:0]  xfa [3];
  logic [7:0]  xfb [3];
  logic [15:0] xfp [3];
  logic [15:0] b_r1 = 16'd0, b_r2 = 16'd0, c_r1 = 16'd0, c_r2 = 16'd0;

  always @(posedge clk) begin
    b_r1 <= smul8(xa[0], xb[0]);
    b_r2 <= b_r1;
    c_r1 <= smul8(xa[1], xb[1]);
    c_r2 <= c_r1;
  end
  assign xp[0] = b_r2;
  assign xp[1] = c_r2;
  assign xp[2] = smul8(xa[2], xb[2]) + 16'd1;

  mult_bist_ctrl #(.WIDTH(8), .NUM_VECTORS(4), .LATENCY(2)) dut_b (
    .clk(clk), .rst_n(rst_x), .start(start_x), .mult_a(xa[0]), .mult_b(xb[0]),
    .mult_product(xp[0]), .busy(busy_x[0]), .done(done_x[0]), .pass(pass_x[0]),
    .err_count(err_x[0]), .fail_a(xfa[0]), .fail_b(xfb[0]), .fail_product(xfp[0])
  );
  mult_bist_ctrl #(.WIDTH(8), .NUM_VECTORS(4), .LATENCY(0)) dut_c (
    .clk(clk), .rst_n(rst_x), .start(start_x), .mult_a(xa[1]), .mult_b(xb[1]),
    .mult_product(xp[1]), .busy(busy_x[1]), .done(done_x[1]), .pass(pass_x[1]),
    .err_count(err_x[1]), .fail_a(xfa[1]), .fail_b(xfb[1]), .fail_product(xfp[1])
  );
  mult_bist_ctrl #(.WIDTH(8), .NUM_VECTORS(65535), .LATENCY(0)) dut_d (
    .clk(clk), .rst_n(rst_x), .start(start_x), .mult_a(xa[2]), .mult_b(xb[2]),
    .mult_product(xp[2]), .busy(busy_x[2]), .done(done_x[2]), .pass(pass_x[2]),
    .err_count(err_x[2]), .fail_a(xfa[2]), .fail_b(xfb[2]), .fail_product(xfp[2])
  );

  // ---------------- scoreboard A: one expected entry per clock edge
  typedef struct {
    bit          full;
    logic [7:0]  a, b;
    logic        busy, done, pass;
    logic [15:0] err;
    logic [7:0]  fa, fb;
    logic [15:0] fp;
  } exp_t;
  exp_t qa[$];

  // Hand-computed operands: directed set, then SEED, SEED>>1, >>2, >>3 (low bit 0 each step).
  logic [7:0] va [7] = '{8'h00, 8'h7F, 8'hFB, 8'h68, 8'h34, 8'h1A, 8'h8D};
  logic [7:0] vb [7] = '{8'h0F, 8'h7F, 8'h0A, 8'h24, 8'h92, 8'h49, 8'h24};

  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_mult_a", 32'(ma), 32'(e.a));
        chk("a_mult_b", 32'(mb), 32'(e.b));
        chk("a_busy", 32'(busy_a), 32'(e.busy));
        chk("a_done", 32'(done_a), 32'(e.done));
        if (e.full) begin
          chk("a_pass", 32'(pass_a), 32'(e.pass));
          chk("a_err_count", 32'(err_a), 32'(e.err));
          chk("a_fail_a", 32'(fa_a), 32'(e.fa));
          chk("a_fail_b", 32'(fb_a), 32'(e.fb));
          chk("a_fail_product", 32'(fp_a), 32'(e.fp));
        end
      end
    end
  end

  function automatic exp_t mk(bit full, logic [7:0] a, logic [7:0] b, logic busy, logic done,
                              logic pass, logic [15:0] err, logic [7:0] fa, logic [7:0] fb,
                              logic [15:0] fp);
    exp_t e;
    e.full = full; e.a = a; e.b = b; e.busy = busy; e.done = done; e.pass = pass;
    e.err = err; e.fa = fa; e.fb = fb; e.fp = fp;
    return e;
  endfunction

  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
  endtask

  task automatic run_a(input bit pulses, input bit faulty);
    logic [7:0]  efa, efb;
    logic [15:0] efp;
    efa = 8'd0; efb = 8'd0; efp = 16'd0;
`ifdef MULT_BIST_FAIL_CAPTURE_EN
    if (faulty) begin efa = 8'h00; efb = 8'h0F; efp = 16'h0001; end
`endif
    fault_a = faulty;
    pulse_start_a();
    for (int k = 0; k < 7; k++) qa.push_back(mk(0, va[k], vb[k], 1, 0, 0, 0, 0, 0, 0));
    qa.push_back(mk(1, va[6], vb[6], 0, 1, !faulty, faulty ? 16'd7 : 16'd0, efa, efb, efp));
    for (int e = 1; e <= 7; e++) begin
      if (pulses && (e == 3 || e == 5)) pulse_start_a();
      else @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1 qa.push_back(mk(1, va[6], vb[6], 0, 1, !faulty, faulty ? 16'd7 : 16'd0, efa, efb, efp));
    repeat (2) @(posedge clk);
  endtask

  task automatic stim_a();
    repeat (2) @(posedge clk);
    #1 qa.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 rst_a = 1'b1;
    run_a(0, 0);
    run_a(1, 0);
    run_a(0, 1);
    // Mid-run reset with a faulty multiplier so there is state to discard.
    fault_a = 1'b1;
    pulse_start_a();
    for (int k = 0; k < 4; k++) qa.push_back(mk(0, va[k], vb[k], 1, 0, 0, 0, 0, 0, 0));
    repeat (4) @(posedge clk);
    #1 rst_a = 1'b0;
    qa.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 rst_a = 1'b1;
    fault_a = 1'b0;
    run_a(0, 0);
  endtask

  // ---------------- scoreboard X: expected final status per instance
  typedef struct {
    int          idx;
    int          done_edge;
    logic [15:0] err;
    bit          err_nonzero;
    logic        pass;
  } fin_t;
  fin_t fq[$];
  bit   seen [3] = '{0, 0, 0};
  int   xedge = -1;

  always @(posedge clk) begin
    if (start_x) xedge <= 0;
    else if (xedge >= 0) xedge <= xedge + 1;
  end

  initial begin : mon_x
    fin_t e;
    bit   found;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (done_x[i] && !seen[i]) begin
          seen[i] = 1'b1;
          found = 1'b0;
          for (int j = 0; j < fq.size(); j++) begin
            if (!found && fq[j].idx == i) begin
              e = fq[j];
              fq.delete(j);
              found = 1'b1;
            end
          end
          if (!found) begin
            checks++; errors++;
            $display("FAIL x%0d_unexpected_done actual 1 required 0", i);
          end else begin
            chk($sformatf("x%0d_done_edge", i), 32'(xedge), 32'(e.done_edge));
            chk($sformatf("x%0d_pass", i), 32'(pass_x[i]), 32'(e.pass));
            chk($sformatf("x%0d_busy", i), 32'(busy_x[i]), 32'd0);
            if (e.err_nonzero) chk($sformatf("x%0d_err_nonzero", i), 32'(err_x[i] != 16'd0), 32'd1);
            else               chk($sformatf("x%0d_err_count", i), 32'(err_x[i]), 32'(e.err));
          end
        end
      end
    end
  end

  task automatic stim_x();
    int n;
    repeat (2) @(posedge clk);
    #1 rst_x = 1'b1;
    @(negedge clk);
    fq.push_back('{0, 9, 16'h0000, 1'b0, 1'b1});
    fq.push_back('{1, 7, 16'h0000, 1'b1, 1'b0});
    fq.push_back('{2, 65538, 16'hFFFF, 1'b0, 1'b0});
    start_x = 1'b1;
    @(posedge clk);
    #1 start_x = 1'b0;
    n = 0;
    while (!(seen[0] && seen[1] && seen[2]) && n < 70000) begin
      @(posedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      if (!seen[i]) begin
        checks++; errors++;
        $display("FAIL x%0d_done_timeout actual 0 required 1", i);
      end
    end
  endtask

  initial begin
    fork
      stim_a();
      stim_x();
    join
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_bist_ctrl.md
# mult_bist_ctrl

Synthesizable built-in self-test controller that sits directly upstream of any signed WIDTH×WIDTH multiplier (ripple-carry, Booth radix-4, Wallace, Dadda). It drives the multiplier's operand inputs with a fixed directed set followed by LFSR pseudo-random vectors. It checks each returned product against an internally computed signed reference after a configurable pipeline latency. It reports done, pass, and an error count, so the multiplier can be verified on silicon or FPGA without a simulator.

## Interface
- WIDTH, 8, operand width; legal range 2..16.
- NUM_VECTORS, 50, number of random vectors after the directed set; legal range 1..65535.
- LATENCY, 0, multiplier register stages. 0 means combinational.
- SEED, 32'hACE1_2468, LFSR reload value; must be nonzero.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a run.
- mult_a  out  WIDTH  signed operand A to the multiplier; registered.
- mult_b  out  WIDTH  signed operand B to the multiplier; registered.
- mult_product  in  2*WIDTH  signed product returned by the multiplier.
- busy  out  1  run in progress.
- done  out  1  sticky run-complete flag.
- pass  out  1  done AND err_count==0; combinational from registers.
- err_count  out  16  mismatch count; saturates at 16'hFFFF.
- fail_a  out  WIDTH  operand A of the first mismatch.
- fail_b  out  WIDTH  operand B of the first mismatch.
- fail_product  out  2*WIDTH  actual product of the first mismatch.

## Operation
- FSM states:
  - IDLE: waiting for a run.
  - DIR: directed vectors.
  - RND: random vectors.
  - DRAIN: waiting for outstanding checks.
  - DONE: run finished.
- Transitions:
  - IDLE or DONE, start=1: go to DIR. On that edge, clear err_count, done and the fail registers, and reload the LFSR with SEED.
  - DIR, after 3 vectors: go to RND.
  - RND, after NUM_VECTORS vectors: go to DRAIN.
  - DRAIN, once the check pipeline is empty: go to DONE.
  - start while busy: ignored.
- Directed vectors, in order:
  1. (0, 15)
  2. (max positive, max positive), i.e. {0,1…1}
  3. (-5, 10)
- Random vectors:
  - LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003).
  - a = lfsr[WIDTH-1:0], b = lfsr[2*WIDTH-1:WIDTH].
  - The LFSR advances one step per random vector issued.
- Issuing a vector: on an issue edge, mult_a/mult_b are loaded. In the same edge, {valid=1, expected=$signed(a)*$signed(b), a, b} enters stage 0 of a check shift pipeline of depth LATENCY+1.
- Non-issue edges shift valid=0 into the pipeline.
- Checking:
  - When the pipeline tail is valid, compare mult_product against the tail's expected value with 2*WIDTH signed exact equality.
  - On mismatch, err_count increments, saturating at 16'hFFFF.
- Holding operands: mult_a/mult_b hold their last value in DRAIN and DONE.

## Timing
- Reset (async assert, sync release): state=IDLE, mult_a=mult_b=0, busy=done=0, err_count=0, fail_*=0, LFSR=SEED, pipeline valids=0. pass=0.
- Cycle numbering: edge 0 is the edge sampling start. Vector k issues at edge k, for k=0..V-1, where V=3+NUM_VECTORS.
- Checks: vector k is checked at edge k+LATENCY+1. The final check happens at edge V+LATENCY.
- Status outputs:
  - busy is 1 from edge 0 up to edge V+LATENCY.
  - done rises at edge V+LATENCY, in the same edge as the final check, so pass already reflects that check.
- Reset mid-run: immediate return to the reset state. No partial results are retained.
- A restart from DONE produces a sequence identical to the previous run.

## Configuration
- MULT_BIST_FAIL_CAPTURE_EN:
  - Defined: on the first mismatch of a run (err_count==0 before the increment), latch the tail's a and b plus mult_product into fail_a, fail_b and fail_product. These hold until the next start or reset.
  - Undefined: the capture logic is omitted and fail_* are constant 0.
  - err_count is unaffected either way.

## Test plan
- Correct combinational multiplier, LATENCY=0, NUM_VECTORS=4, WIDTH=8 -> operands (0,15), (127,127), (-5,10) at edges 0-2. done and pass rise at edge 7. err_count=0. busy is low after edge 7.
- Faulty multiplier returning a*b+1, same parameters, capture enabled -> err_count=7, pass=0, fail_a=0, fail_b=15, fail_product=1. With the macro undefined, fail_* are 0.
- Correct multiplier wrapped in 2 register stages, LATENCY=2, NUM_VECTORS=4 -> pass=1, done at edge 9, err_count=0. The same DUT run with LATENCY=0 gives err_count>0.
- start pulsed at edges 3 and 5 of a run -> both ignored. The run completes at the same edge with unchanged results. A second start after done repeats identical mult_a/mult_b sequences.
- rst_n low at edge 4 of a run -> all outputs return to 0 immediately, with no done. A subsequent start runs a full, correct sequence.
- Faulty multiplier with NUM_VECTORS=65535 -> err_count saturates at 16'hFFFF and does not wrap.
